// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and muldiv_unit.
// The master side is the core; the slave side is the multiply-divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, rs1, rs2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, rs1, rs2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide, generalised to XLEN bits.
// Multiplies are radix-2 shift-add on magnitudes, divides are restoring on
// magnitudes; signs are applied on the last step. Divide-by-zero and signed
// overflow bypass the iteration and complete in one clock.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a combinational
// 2*XLEN product and complete in one clock; divides stay iterative.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; operands, op and signs captured on accept
// S_CALC | one radix-2 step per clock, cnt_q counts XLEN-1 down to 0
// S_DONE | result_q valid; held until out_ready
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;
  logic              rneg_q;
  logic [XLEN-1:0]   result_q;
  logic              accept;

  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;
  logic              div_zero, div_ovf, special, fast_hit;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fin;
  logic [XLEN-1:0]   quo, rem, calc_res;

  // Request decode: operand signs, magnitudes and the one-clock special cases.
  always_comb begin
    a_signed = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV) || (bus.op == OP_REM);
    b_signed = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
               (bus.op == OP_DIV) || (bus.op == OP_REM);
    sa       = a_signed & bus.rs1[XLEN-1];
    sb       = b_signed & bus.rs2[XLEN-1];
    a_mag    = sa ? -bus.rs1 : bus.rs1;
    b_mag    = sb ? -bus.rs2 : bus.rs2;
    div_zero = bus.op[2] && (bus.rs2 == '0);
    div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.rs1 == MOST_NEG) && (bus.rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) spec_res = bus.op[1] ? bus.rs1 : '1;
    else          spec_res = bus.op[1] ? '0 : bus.rs1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_abs, fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Single-clock multiply from the request operands, signed via magnitudes.
  always_comb begin
    fast_abs  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_prod = (sa ^ sb) ? -fast_abs : fast_abs;
    fast_res  = (bus.op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    fast_hit  = ~bus.op[2];
  end
`else
  assign fast_hit = 1'b0;
`endif

  // One iteration step for both algorithms, plus sign fix-up for the last step.
  // acc_q holds the running product for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    if (div_diff[XLEN]) div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    prod_fin = neg_q  ? -mul_next : mul_next;
    quo      = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
    rem      = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    if (op_q[2]) calc_res = op_q[1] ? rem : quo;
    else         calc_res = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and accept decode; flush overrides everything.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = (special || fast_hit) ? S_DONE : S_CALC;
      end
      S_CALC: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      accept  = 1'b0;
    end
  end

  // Datapath: capture on accept, iterate in CALC, register the final result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      neg_q  <= sa ^ sb;
      rneg_q <= sa;
      cnt_q  <= CNT_W'(XLEN - 1);
      if (bus.op[2]) begin
        mcand_q <= b_mag;
        acc_q   <= {{XLEN{1'b0}}, a_mag};
      end else begin
        mcand_q <= a_mag;
        acc_q   <= {{XLEN{1'b0}}, b_mag};
      end
      if (special) result_q <= spec_res;
`ifdef MULDIV_FAST_MUL_EN
      else if (fast_hit) result_q <= fast_res;
`endif
    end else if ((state_q == S_CALC) && !bus.flush) begin
      acc_q <= op_q[2] ? div_next : mul_next;
      if (cnt_q == '0) result_q <= calc_res;
      else             cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN=32).
// Driver pushes the expected result and latency on each accept; a monitor
// checks state, latency, hold-under-backpressure and results at negedge.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  bit          rand_bp = 1'b0;
  bit          ov_prev = 1'b0;
  bit          ctl_prev = 1'b0;
  bit          rst_prev = 1'b0;
  logic [31:0] res_prev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on sign-extended 64-bit values.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return FAST ? 1 : XLEN + 1;
    if (b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(1, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.rs1 = a;
    bus.rs2 = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush && !rst) begin
        q.push_back('{res: e, lat: ref_lat(o, a, b), acc: cyc});
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.rs1 = $urandom;
    bus.rs2 = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !bus.in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: forced stall for stall_cnt DONE cycles, else always/randomly ready.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      bus.out_ready = 1'b0;
      if (bus.out_valid) stall_cnt--;
    end else begin
      bus.out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares outputs against the scoreboard at every negedge.
  always @(negedge clk) begin
    bit inflight;
    if (cyc > 0) begin
      if (ctl_prev) begin
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        if (rst_prev) chk("reset_result", bus.result, 32'd0);
      end
      inflight = (q.size() > 0) && (cyc > q[0].acc);
      if (inflight) begin
        chk("busy", 32'(bus.busy), 32'd1);
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid && !ov_prev) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        if (bus.out_valid && ov_prev) chk("hold_result", bus.result, res_prev);
        if (bus.out_valid && bus.out_ready) begin
          chk("result", bus.result, q[0].res);
          void'(q.pop_front());
        end
      end else begin
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
      end
    end
    ov_prev  = bus.out_valid;
    res_prev = bus.result;
    ctl_prev = rst || bus.flush;
    rst_prev = rst;
    if (rst || bus.flush) q.delete();
  end

  // Stimulus.
  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'd1, MIN, MIN, 32'h4000_0000);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    issue(3'd7, 32'd100, 32'd7, 32'd2);
    issue(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue(3'd7, 32'd5, 32'd0, 32'd5);
    issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue(3'd6, 32'd5, 32'd0, 32'd5);
    issue(3'd4, MIN, 32'hFFFF_FFFF, MIN);
    issue(3'd6, MIN, 32'hFFFF_FFFF, 32'd0);
    drain();

    // Backpressure: ten DONE cycles without out_ready, next request held valid.
    stall_cnt = 10;
    issue(3'd0, 32'd3, 32'd5, 32'd15);
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    drain();

    // Flush on the 5th CALC clock together with a new request.
    issue(3'd5, 32'd1000, 32'd3, 32'd333);
    repeat (4) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 3'd5;
    bus.rs1 = 32'd50;
    bus.rs2 = 32'd5;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    // Flush with a request while idle.
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    issue(3'd5, 32'd9, 32'd3, 32'd3);
    drain();

    // Same abort via reset; result must read zero afterwards.
    issue(3'd4, 32'd12345, 32'd7, ref_res(3'd4, 32'd12345, 32'd7));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(3'd5, 32'd9, 32'd3, 32'd3);
    drain();

    // Random ops under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(o, a, b, ref_res(o, a, b));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog in case the handshake never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
